// File: rtl/bus_initiator_if.sv
// Transfer-size encodings and the bstart/bdone system bus interface shared by
// the initiator and the memory/peripheral responders.
package bus_pkg;
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } tsize_e;
endpackage

interface master_bus_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [1:0]  tsize;
    logic        bstart;
    logic [31:0] rdata;
    logic        bdone;

    modport master (output addr, wdata, write, tsize, bstart,
                    input  rdata, bdone);
    modport slave  (input  addr, wdata, write, tsize, bstart,
                    output rdata, bdone);
endinterface

// File: rtl/bus_initiator.sv
// Single-outstanding bus initiator: accepts a core request, runs one bstart/bdone
// transaction with a timeout, and returns data or an error on a one-cycle strobe.
module bus_initiator
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [31:0]  req_addr,
    input  logic [31:0]  req_wdata,
    input  logic [1:0]   req_tsize,
    output logic         resp_valid,
    output logic [31:0]  resp_rdata,
    output logic         resp_error,
    master_bus_if.master bus
);
    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_e;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_e      state;
    state_e      state_nxt;
    logic [15:0] wait_cnt;
    logic        accept;
    logic        misaligned;
    logic        cnt_last;

    function automatic logic is_misaligned(input logic [1:0] tsize, input logic [1:0] addr_lsb);
        case (tsize)
            HALF:    is_misaligned = addr_lsb[0];
            WORD:    is_misaligned = (addr_lsb != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

    assign misaligned = is_misaligned(req_tsize, req_addr[1:0]);
    assign accept     = req_valid && (state == IDLE);
    assign cnt_last   = (wait_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        bus.bstart = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = misaligned ? RESP : START;
            end
            START: begin
                bus.bstart = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                if (bus.bdone || cnt_last) state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus fields only move on an aligned acceptance, so a rejected request leaves the bus untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.addr   <= '0;
            bus.wdata  <= '0;
            bus.write  <= 1'b0;
            bus.tsize  <= WORD;
            wait_cnt   <= '0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else begin
            if (accept && !misaligned) begin
                bus.addr  <= req_addr;
                bus.wdata <= req_wdata;
                bus.write <= req_write;
                bus.tsize <= req_tsize;
                wait_cnt  <= '0;
            end
            if (accept && misaligned) begin
                resp_rdata <= '0;
                resp_error <= 1'b1;
            end
            if (state == WAIT) begin
                if (bus.bdone) begin
                    resp_rdata <= bus.write ? 32'h0 : bus.rdata;
                    resp_error <= 1'b0;
                end else if (cnt_last) begin
                    resp_rdata <= '0;
                    resp_error <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
            end
        end
    end
endmodule
